// File: rtl/and_gate.sv
// 32-bit bitwise AND slice for the ALU datapath: combinational result and zero
// flag, plus a registered copy of both for pipelined consumers.
module and_gate (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  input  logic        clock,
  input  logic        reset,
  output logic        zero,
  output logic [31:0] out_q,
  output logic        zero_q
);

  localparam int unsigned W = 32;

  logic [15:0] or16;
  logic [7:0]  or8;
  logic [3:0]  or4;
  logic [1:0]  or2;
  logic        or1;

  // One 2-input AND per bit, same structural shape as the neighbouring slices.
  for (genvar k = 0; k < W; k++) begin : g_and
    assign out[k] = A[k] & B[k];
  end

  // Balanced OR tree 32->16->8->4->2->1, then inverted to form the zero flag.
  for (genvar i = 0; i < 16; i++) begin : g_or16
    assign or16[i] = out[2*i] | out[2*i+1];
  end
  for (genvar i = 0; i < 8; i++) begin : g_or8
    assign or8[i] = or16[2*i] | or16[2*i+1];
  end
  for (genvar i = 0; i < 4; i++) begin : g_or4
    assign or4[i] = or8[2*i] | or8[2*i+1];
  end
  for (genvar i = 0; i < 2; i++) begin : g_or2
    assign or2[i] = or4[2*i] | or4[2*i+1];
  end
  assign or1  = or2[0] | or2[1];
  assign zero = ~or1;

  // Registered copy; reset value matches the zero result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out;
      zero_q <= zero;
    end
  end

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: combinational sweep and patterns, then the
// registered path (async reset, load, hold, back-to-back stream) via a scoreboard.
module tb_and_gate;

  typedef struct packed {
    logic [31:0] out;
    logic        zero;
  } exp_t;

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;
  logic        zero;
  logic [31:0] out_q;
  logic        zero_q;
  logic        reset;
  logic        clk_gen;
  logic        clk_en;
  wire         clock;

  int checks;
  int failures;

  exp_t comb_q[$];
  exp_t reg_q[$];

  assign clock = clk_en ? clk_gen : 1'bz;

  and_gate dut (
    .A     (a),
    .B     (b),
    .out   (out),
    .clock (clock),
    .reset (reset),
    .zero  (zero),
    .out_q (out_q),
    .zero_q(zero_q)
  );

  initial clk_gen = 1'b0;
  always #5 clk_gen = ~clk_gen;

  initial begin
    #50000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.out  = x & y;
    e.zero = ((x & y) == 32'h0);
    return e;
  endfunction

  // Drive operands and push the combinational expectation.
  task automatic drive_comb(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    comb_q.push_back(model(x, y));
  endtask

  task automatic check_comb(input string name);
    exp_t e;
    checks++;
    if (comb_q.size() == 0) begin
      failures++;
      $display("FAIL %s comb scoreboard empty", name);
      return;
    end
    e = comb_q.pop_front();
    if (out !== e.out) begin
      failures++;
      $display("FAIL %s out got=%h exp=%h", name, out, e.out);
    end
    checks++;
    if (zero !== e.zero) begin
      failures++;
      $display("FAIL %s zero got=%b exp=%b", name, zero, e.zero);
    end
  endtask

  task automatic check_reg(input string name);
    exp_t e;
    checks++;
    if (reg_q.size() == 0) begin
      failures++;
      $display("FAIL %s reg scoreboard empty", name);
      return;
    end
    e = reg_q.pop_front();
    if (out_q !== e.out) begin
      failures++;
      $display("FAIL %s out_q got=%h exp=%h", name, out_q, e.out);
    end
    checks++;
    if (zero_q !== e.zero) begin
      failures++;
      $display("FAIL %s zero_q got=%b exp=%b", name, zero_q, e.zero);
    end
  endtask

  task automatic test_sweep();
    clk_en = 1'b0;
    reset  = 1'bx;
    for (int i = 0; i < 10; i++) begin
      drive_comb(32'(i), 32'(i));
      #10;
      check_comb($sformatf("sweep_%0d", i));
    end
  endtask

  task automatic test_patterns();
    drive_comb(32'hFFFF_FFFF, 32'h1234_5678); #1; check_comb("pat_mask");
    drive_comb(32'hAAAA_AAAA, 32'h5555_5555); #1; check_comb("pat_disjoint");
    drive_comb(32'h8000_0001, 32'hFFFF_FFFF); #1; check_comb("pat_msb_lsb");
    drive_comb(32'h0000_0000, 32'hFFFF_FFFF); #1; check_comb("pat_zero_a");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    reg_q.push_back('{out: 32'h0, zero: 1'b1});
    check_reg("reset_async");
    @(negedge clk_gen);
    clk_en = 1'b1;
    @(posedge clk_gen); #1;
    reg_q.push_back('{out: 32'h0, zero: 1'b1});
    check_reg("reset_held_edge");
  endtask

  task automatic test_registered();
    @(negedge clk_gen);
    reset = 1'b0;
    drive_comb(32'h0000_00F0, 32'h0000_00F0);
    reg_q.push_back(model(32'h0000_00F0, 32'h0000_00F0));
    #1; check_comb("load_comb");
    @(posedge clk_gen); #1;
    check_reg("load_f0");
  endtask

  task automatic test_hold();
    @(negedge clk_gen);
    drive_comb(32'h0000_000F, 32'h0000_00F0);
    #1; check_comb("hold_comb");
    reg_q.push_back(model(32'h0000_00F0, 32'h0000_00F0));
    check_reg("hold_before_edge");
    reg_q.push_back(model(32'h0000_000F, 32'h0000_00F0));
    @(posedge clk_gen); #1;
    check_reg("hold_after_edge");
  endtask

  task automatic test_midrun_reset();
    @(negedge clk_gen);
    a = 32'h0000_00F0;
    reg_q.push_back(model(32'h0000_00F0, 32'h0000_00F0));
    @(posedge clk_gen); #1;
    check_reg("midrun_preload");
    #2;
    reset = 1'b1;
    comb_q.push_back(model(32'h0000_00F0, 32'h0000_00F0));
    reg_q.push_back('{out: 32'h0, zero: 1'b1});
    #1;
    check_reg("midrun_reset_q");
    check_comb("midrun_reset_comb");
    @(negedge clk_gen);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      y = (i % 5 == 0) ? ~x : $urandom;
      @(negedge clk_gen);
      drive_comb(x, y);
      reg_q.push_back(model(x, y));
      #1; check_comb($sformatf("b2b_comb_%0d", i));
      @(posedge clk_gen); #1;
      check_reg($sformatf("b2b_reg_%0d", i));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk_en   = 1'b0;
    a        = '0;
    b        = '0;
    reset    = 1'b0;
    test_sweep();
    test_patterns();
    test_reset();
    test_registered();
    test_hold();
    test_midrun_reset();
    test_back_to_back();
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover comb=%0d reg=%0d exp=0", comb_q.size(), reg_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
